// File: rtl/jtopl_mmr_wrq.sv
`default_nettype none
// ============================================================================
// Module      : jtopl_mmr_wrq
// Description : Queued, bank-aware OPL register front end. CPU writes are
//               buffered at clk rate and committed at cen rate as strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module jtopl_mmr_wrq #(
    parameter int CH    = 18,
    parameter int DEPTH = 4,
    parameter int WAITC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic [7:0] dout,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic [4:0] sel_ch,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_fnum_lo,
    output logic       up_fnum_hi,
    output logic       up_fbcon,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flag,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       new3
);

    localparam int            c_AW       = $clog2(DEPTH);
    localparam int            c_WW       = (WAITC > 1) ? $clog2(WAITC) : 1;
    localparam int            c_WL       = (WAITC > 0) ? WAITC - 1 : 0;
    localparam logic [c_AW:0] c_DEPTH    = DEPTH[c_AW:0];
    localparam logic [c_WW-1:0] c_WLAST  = c_WL[c_WW-1:0];
    localparam logic          c_TWO_BANK = (CH > 9);
    localparam logic          c_HAS_HOLD = (WAITC > 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_WW-1:0] r_wcnt;
    logic [c_WW-1:0] w_wcnt_nxt;

    logic [16:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic [8:0]      r_selreg;

    logic        w_pop;
    logic        w_push;
    logic        w_dwr;
    logic        w_awr;
    logic        w_abank;
    logic [16:0] w_head;
    logic        w_bnk;
    logic [7:0]  w_reg;
    logic [7:0]  w_dat;
    logic [4:0]  w_boff;
    logic        w_is_op;
    logic        w_is_ch;
    logic [6:0]  w_up_nxt;
    logic [1:0]  w_grp_nxt;
    logic [2:0]  w_sub_nxt;
    logic [4:0]  w_ch_nxt;
    logic [1:0]  w_osub;

    assign w_dwr   = write &  addr[0];
    assign w_awr   = write & ~addr[0];
    assign w_pop   = cen && (r_state == S_IDLE) && (r_count != '0);
    assign w_push  = w_dwr && ((r_count != c_DEPTH) || w_pop);
    assign w_head  = r_mem[r_rptr];
    assign w_bnk   = w_head[16];
    assign w_reg   = w_head[15:8];
    assign w_dat   = w_head[7:0];
    assign w_boff  = w_bnk ? 5'd9 : 5'd0;

    // Bank 1 is only reachable in OPL3 mode, except for the mode register itself
    assign w_abank = c_TWO_BANK && addr[1] && (new3 || (din == 8'h05));

    assign busy = (r_count != '0) || (r_state != S_IDLE);
    assign full = (r_count == c_DEPTH);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_selreg, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_selreg <= 9'd0;
            ovf      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_awr) begin
                r_selreg <= {w_abank, din};
            end
            if (w_dwr && !w_push) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (cen) begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = c_HAS_HOLD ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (cen) begin
                    if (r_wcnt == c_WLAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wcnt_nxt = r_wcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_is_op = (w_reg >= 8'h20) && (w_reg <= 8'h9F) &&
                     (w_reg[2:0] <= 3'd5) && (w_reg[4:3] != 2'd3);
    assign w_is_ch = ((w_reg[7:4] == 4'hA) || (w_reg[7:4] == 4'hB) ||
                      (w_reg[7:4] == 4'hC)) && (w_reg[3:0] <= 4'd8);

    always_comb begin
        w_up_nxt  = 7'd0;
        w_grp_nxt = 2'd0;
        w_sub_nxt = 3'd0;
        w_ch_nxt  = 5'd0;
        w_osub    = 2'd0;
        if (w_is_op) begin
            // Operator slots map onto the channel group*3 + subslot%3
            w_grp_nxt = w_reg[4:3];
            w_sub_nxt = w_reg[2:0];
            w_osub    = (w_reg[2:0] >= 3'd3) ? 2'(w_reg[2:0] - 3'd3) : w_reg[1:0];
            w_ch_nxt  = w_boff + {2'b00, w_reg[4:3], 1'b0} + {3'b000, w_reg[4:3]}
                        + {3'b000, w_osub};
            case (w_reg[7:5])
                3'd1:    w_up_nxt[0] = 1'b1;
                3'd2:    w_up_nxt[1] = 1'b1;
                3'd3:    w_up_nxt[2] = 1'b1;
                3'd4:    w_up_nxt[3] = 1'b1;
                default: w_up_nxt    = 7'd0;
            endcase
        end else if (w_is_ch) begin
            case (w_reg[7:4])
                4'hA:    w_up_nxt[4] = 1'b1;
                4'hB:    w_up_nxt[5] = 1'b1;
                default: w_up_nxt[6] = 1'b1;
            endcase
            case (w_reg[3:0])
                4'd0, 4'd1, 4'd2: w_grp_nxt = 2'd0;
                4'd3, 4'd4, 4'd5: w_grp_nxt = 2'd1;
                default:          w_grp_nxt = 2'd2;
            endcase
            case (w_reg[3:0])
                4'd0, 4'd3, 4'd6: w_sub_nxt = 3'd0;
                4'd1, 4'd4, 4'd7: w_sub_nxt = 3'd1;
                default:          w_sub_nxt = 3'd2;
            endcase
            w_ch_nxt = w_boff + {1'b0, w_reg[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 8'd0;
            sel_bank   <= 1'b0;
            sel_group  <= 2'd0;
            sel_sub    <= 3'd0;
            sel_ch     <= 5'd0;
            up_mult    <= 1'b0;
            up_ksl_tl  <= 1'b0;
            up_ar_dr   <= 1'b0;
            up_sl_rr   <= 1'b0;
            up_fnum_lo <= 1'b0;
            up_fnum_hi <= 1'b0;
            up_fbcon   <= 1'b0;
            value_A    <= 8'd0;
            value_B    <= 8'd0;
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            flagen_A   <= 1'b1;
            flagen_B   <= 1'b1;
            clr_flag   <= 1'b0;
            am_dep     <= 1'b0;
            vib_dep    <= 1'b0;
            new3       <= 1'b0;
        end else begin
            if (cen && (r_state == S_STROBE)) begin
                {up_fbcon, up_fnum_hi, up_fnum_lo, up_sl_rr,
                 up_ar_dr, up_ksl_tl, up_mult} <= 7'd0;
                clr_flag <= 1'b0;
            end
            if (w_pop) begin
                {up_fbcon, up_fnum_hi, up_fnum_lo, up_sl_rr,
                 up_ar_dr, up_ksl_tl, up_mult} <= w_up_nxt;
                dout      <= w_dat;
                sel_bank  <= w_bnk;
                sel_group <= w_grp_nxt;
                sel_sub   <= w_sub_nxt;
                sel_ch    <= w_ch_nxt;
                if (!w_bnk) begin
                    case (w_reg)
                        8'h02: value_A <= w_dat;
                        8'h03: value_B <= w_dat;
                        8'h04: begin
                            // IRQ reset takes precedence and leaves timer control untouched
                            if (w_dat[7]) begin
                                clr_flag <= 1'b1;
                            end else begin
                                flagen_A <= ~w_dat[6];
                                flagen_B <= ~w_dat[5];
                                load_B   <= w_dat[1];
                                load_A   <= w_dat[0];
                            end
                        end
                        8'hBD: begin
                            am_dep  <= w_dat[7];
                            vib_dep <= w_dat[6];
                        end
                        default: begin
                        end
                    endcase
                end else if (w_reg == 8'h05) begin
                    new3 <= w_dat[0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtopl_mmr_wrq.sv
`default_nettype none
// Bench for jtopl_mmr_wrq: queue/timing model checked every clk, plus directed
// vectors with literal expectations.
module tb_jtopl_mmr_wrq;

    localparam int CH    = 18;
    localparam int DEPTH = 4;
    localparam int WAITC = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen   = 1'b0;
    logic [7:0] din   = 8'd0;
    logic [1:0] addr  = 2'd0;
    logic       write = 1'b0;

    logic       busy, full, ovf;
    logic [7:0] dout;
    logic       sel_bank;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [4:0] sel_ch;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum_lo, up_fnum_hi, up_fbcon;
    logic [7:0] value_A, value_B;
    logic       load_A, load_B, flagen_A, flagen_B, clr_flag, am_dep, vib_dep, new3;
    logic [6:0] strb;

    assign strb = {up_fbcon, up_fnum_hi, up_fnum_lo, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

    always #5 clk = ~clk;

    jtopl_mmr_wrq #(.CH(CH), .DEPTH(DEPTH), .WAITC(WAITC)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .addr(addr), .write(write),
        .busy(busy), .full(full), .ovf(ovf), .dout(dout),
        .sel_bank(sel_bank), .sel_group(sel_group), .sel_sub(sel_sub), .sel_ch(sel_ch),
        .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
        .up_fnum_lo(up_fnum_lo), .up_fnum_hi(up_fnum_hi), .up_fbcon(up_fbcon),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag),
        .am_dep(am_dep), .vib_dep(vib_dep), .new3(new3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // cen: one tick every third clk while running
    logic cen_run = 1'b1;
    int   div     = 0;
    always @(negedge clk) begin
        div = (div == 2) ? 0 : div + 1;
        cen = cen_run && (div == 0);
    end

    // ---------------- behavioural model ----------------
    logic [16:0] m_q[$];
    logic [8:0]  m_selreg;
    int          m_since;
    int          n_tick = 0;
    logic [6:0]  m_up;
    logic [7:0]  m_dout, m_va, m_vb;
    logic        m_bank, m_clr, m_la, m_lb, m_fa, m_fb, m_am, m_vib, m_new3, m_ovf;
    logic [1:0]  m_grp;
    logic [2:0]  m_sub;
    logic [4:0]  m_ch;

    task automatic m_reset();
        m_q.delete();
        m_selreg = 9'd0; m_since = 100; m_up = 7'd0; m_dout = 8'd0;
        m_va = 8'd0; m_vb = 8'd0; m_bank = 1'b0; m_clr = 1'b0;
        m_la = 1'b0; m_lb = 1'b0; m_fa = 1'b1; m_fb = 1'b1;
        m_am = 1'b0; m_vib = 1'b0; m_new3 = 1'b0; m_ovf = 1'b0;
        m_grp = 2'd0; m_sub = 3'd0; m_ch = 5'd0;
    endtask

    task automatic m_apply(input logic [16:0] e);
        int b, r, lo;
        b = int'(e[16]);
        r = int'(e[15:8]);
        lo = r % 16;
        m_dout = e[7:0];
        m_bank = e[16];
        if (r >= 32 && r <= 159 && (r % 8) <= 5 && ((r / 8) % 4) != 3) begin
            m_up[r / 32 - 1] = 1'b1;
            m_grp = 2'((r / 8) % 4);
            m_sub = 3'(r % 8);
        end else if (r / 16 >= 10 && r / 16 <= 12 && lo <= 8) begin
            m_up[4 + r / 16 - 10] = 1'b1;
            m_grp = 2'(lo / 3);
            m_sub = 3'(lo % 3);
            m_ch  = 5'(b * 9 + lo);
        end
        if (b == 0) begin
            if (r == 2) m_va = e[7:0];
            if (r == 3) m_vb = e[7:0];
            if (r == 4) begin
                if (e[7]) m_clr = 1'b1;
                else begin
                    m_fa = ~e[6]; m_fb = ~e[5]; m_lb = e[1]; m_la = e[0];
                end
            end
            if (r == 8'hBD) begin
                m_am = e[7]; m_vib = e[6];
            end
        end else if (r == 5) begin
            m_new3 = e[0];
        end
    endtask

    task automatic m_step();
        if (write && !addr[0])
            m_selreg = {(CH > 9) && addr[1] && (m_new3 || din == 8'h05), din};
        if (cen) begin
            n_tick++;
            m_since = (m_since >= 100) ? 100 : m_since + 1;
            if (m_since == 1) begin
                m_up = 7'd0; m_clr = 1'b0;
            end
            if (m_since >= WAITC + 2 && m_q.size() > 0) begin
                m_apply(m_q.pop_front());
                m_since = 0;
            end
        end
        if (write && addr[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back({m_selreg, din});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic m_compare();
        logic m_busy;
        m_busy = (m_q.size() > 0) || (m_since < WAITC + 1);
        chk("strobes", strb, m_up);
        chk("status busy/full/ovf", {busy, full, ovf}, {m_busy, m_q.size() == DEPTH, m_ovf});
        chk("timer ctl", {load_B, load_A, flagen_B, flagen_A, clr_flag},
            {m_lb, m_la, m_fb, m_fa, m_clr});
        chk("value_A/B", {value_A, value_B}, {m_va, m_vb});
        chk("globals", {am_dep, vib_dep, new3}, {m_am, m_vib, m_new3});
        if (|m_up) begin
            chk("dout/bank/grp/sub", {dout, sel_bank, sel_group, sel_sub},
                {m_dout, m_bank, m_grp, m_sub});
            if (|m_up[6:4]) chk("sel_ch", sel_ch, m_ch);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
        #1;
        m_compare();
    end

    // ---------------- directed stimulus ----------------
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; din = d; write = 1'b1;
        @(negedge clk); write = 1'b0;
    endtask

    task automatic wait_up(input int idx);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (strb[idx]) break;
        end
        chk("strobe seen", 32'(strb[idx]), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int t0, t1, n;
        logic prev;
        repeat (3) @(negedge clk);
        #1;
        chk("reset flagen", {flagen_A, flagen_B}, 2'b11);
        chk("reset busy/full/ovf", {busy, full, ovf}, 3'b000);
        chk("reset strobes", strb, 7'd0);
        @(negedge clk); rst_n = 1'b1;

        // operator write and commit spacing
        wr(2'd0, 8'h20); wr(2'd1, 8'h21); wr(2'd1, 8'h22);
        wait_up(0);
        t0 = n_tick;
        chk("mult sel", {dout, sel_bank, sel_group, sel_sub}, {8'h21, 1'b0, 2'd0, 3'd0});
        for (int i = 0; i < 50 && strb[0]; i++) @(negedge clk);
        wait_up(0);
        t1 = n_tick;
        chk("commit spacing", t1 - t0, WAITC + 2);
        chk("second dout", dout, 8'h22);
        wait_idle();

        // OPL3 bank 1 channel write
        wr(2'd2, 8'h05); wr(2'd3, 8'h01);
        wait_idle();
        chk("new3 set", new3, 1'b1);
        wr(2'd2, 8'hA4); wr(2'd3, 8'h55);
        wait_up(4);
        chk("bank1 fnum_lo", {sel_bank, sel_ch, sel_group, sel_sub, dout},
            {1'b1, 5'd13, 2'd1, 3'd1, 8'h55});
        wait_idle();

        // new3 cleared: bank 1 access folds onto bank 0
        wr(2'd2, 8'h05); wr(2'd3, 8'h00);
        wait_idle();
        chk("new3 clear", new3, 1'b0);
        wr(2'd2, 8'hB0); wr(2'd3, 8'h3C);
        wait_up(5);
        chk("folded bank", {sel_bank, sel_ch, dout}, {1'b0, 5'd0, 8'h3C});
        wait_idle();

        // overflow with cen stalled
        cen_run = 1'b0;
        repeat (4) @(negedge clk);
        wr(2'd0, 8'hA1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk); addr = 2'd1; din = 8'(i + 8'h10); write = 1'b1;
        end
        @(negedge clk); write = 1'b0;
        chk("full/ovf", {full, ovf}, 2'b11);
        cen_run = 1'b1;
        n = 0; prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (strb[4] && !prev) n++;
            prev = strb[4];
            if (!busy) break;
        end
        chk("commits after ovf", n, DEPTH);

        // timer control and flag clear
        wr(2'd0, 8'h04); wr(2'd1, 8'h62);
        wait_idle();
        chk("tctl 62", {flagen_A, flagen_B, load_B, load_A}, 4'b0010);
        wr(2'd1, 8'h80);
        for (int i = 0; i < 300 && !clr_flag; i++) @(negedge clk);
        chk("clr_flag pulse", clr_flag, 1'b1);
        chk("tctl held", {flagen_A, flagen_B, load_B, load_A}, 4'b0010);
        wait_idle();
        chk("clr_flag done", clr_flag, 1'b0);
        wr(2'd1, 8'h03);
        wait_idle();
        chk("tctl 03", {flagen_A, flagen_B, load_B, load_A}, 4'b1111);
        wr(2'd0, 8'hBD); wr(2'd1, 8'hC0); wr(2'd0, 8'h02); wr(2'd1, 8'h5A);
        wait_idle();
        chk("am/vib/valA", {am_dep, vib_dep, value_A}, {2'b11, 8'h5A});

        // reset in the middle of a strobe with a write still queued
        wr(2'd0, 8'h40); wr(2'd1, 8'h3F); wr(2'd1, 8'h3E);
        wait_up(1);
        rst_n = 1'b0;
        #1;
        chk("midrst strobes", strb, 7'd0);
        chk("midrst status", {busy, full, ovf}, 3'b000);
        chk("midrst tctl", {flagen_A, flagen_B, load_B, load_A}, 4'b1100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("queue lost", {busy, strb}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
